// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter, start handshake, next-PC selection
// (relative branch / absolute jump / sequential) and halt detection for
// the single-cycle processor. Also keeps a saturating RUN-cycle counter.
module fetch_ctrl #(
  parameter int D         = 12,
  parameter int HALT_ADDR = 128,
  parameter int CW        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [D-1:0] start_address,
  input  logic         branch,
  input  logic         taken,
  input  logic         jump,
  input  logic [D-1:0] target,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_en,
  output logic         done,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [D-1:0]  HALT_PC = D'(HALT_ADDR);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_reg;
  logic [D-1:0]  pc_reg;
  logic [CW-1:0] cnt_reg;
  logic          fetch_en_reg;
  logic          done_reg;

  // Sequential next-PC target used in RUN when no redirect/halt applies.
  // The branch offset is two's complement, so a plain D-bit add wraps it
  // correctly modulo 2^D.
  logic [D-1:0] pc_seq;
  logic [D-1:0] pc_branch;
  logic [CW-1:0] cnt_inc;

  assign pc_seq    = pc_reg + D'(1);
  assign pc_branch = pc_reg + target;
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

  // FSM, program counter, cycle counter and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= '0;
      cnt_reg      <= '0;
      fetch_en_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= ARMED;
            pc_reg       <= start_address;
            cnt_reg      <= '0;
            fetch_en_reg <= 1'b0;
            done_reg     <= 1'b0;
          end
        end

        ARMED: begin
          // Keep tracking the start address until start drops; the PC
          // then already points at the first instruction.
          pc_reg  <= start_address;
          cnt_reg <= '0;
          if (!start) begin
            state_reg    <= RUN;
            fetch_en_reg <= 1'b1;
            done_reg     <= 1'b0;
          end
        end

        RUN: begin
          if (start) begin
            state_reg    <= ARMED;
            pc_reg       <= start_address;
            cnt_reg      <= '0;
            fetch_en_reg <= 1'b0;
            done_reg     <= 1'b0;
          end else if (pc_reg == HALT_PC || halt) begin
            // The instruction at the current PC is not committed; PC holds.
            state_reg    <= DONE;
            cnt_reg      <= cnt_inc;
            fetch_en_reg <= 1'b0;
            done_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
            if (jump)
              pc_reg <= target;
            else if (branch && taken)
              pc_reg <= pc_branch;
            else
              pc_reg <= pc_seq;
          end
        end

        DONE: begin
          if (start) begin
            state_reg    <= ARMED;
            pc_reg       <= start_address;
            cnt_reg      <= '0;
            fetch_en_reg <= 1'b0;
            done_reg     <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          fetch_en_reg <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr  = pc_reg;
  assign fetch_en  = fetch_en_reg;
  assign done      = done_reg;
  assign cycle_cnt = cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;

  localparam int D  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [D-1:0]  start_address;
  logic          branch;
  logic          taken;
  logic          jump;
  logic [D-1:0]  target;
  logic          halt;
  logic [D-1:0]  prog_ctr;
  logic          fetch_en;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fetch_ctrl #(.D(D), .HALT_ADDR(128), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_address(start_address),
    .branch(branch), .taken(taken), .jump(jump), .target(target),
    .halt(halt), .prog_ctr(prog_ctr), .fetch_en(fetch_en), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    branch = 1'b0; taken = 1'b0; jump = 1'b0; halt = 1'b0; target = '0;
  endtask

  // Enter ARMED at addr for one cycle, then drop start into RUN.
  task automatic arm(input logic [D-1:0] addr);
    start = 1'b1; start_address = addr;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_address = 12'h3AB; clear_ctrl();
    step(); step();
    total_cnt++; if (prog_ctr !== 12'h000) $display("FAIL reset_pc got %h exp 000", prog_ctr); else pass_cnt++;
    total_cnt++; if (fetch_en !== 1'b0) $display("FAIL reset_fetch_en got %b exp 0", fetch_en); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", cycle_cnt); else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++; if (prog_ctr !== 12'h000 || fetch_en !== 1'b0) $display("FAIL idle_hold got pc %h fe %b exp 000 0", prog_ctr, fetch_en); else pass_cnt++;
    $display("reset: pc=%h fetch_en=%b done=%b cnt=%0d", prog_ctr, fetch_en, done, cycle_cnt);
  endtask

  task automatic test_start_run();
    start = 1'b1; start_address = 12'h010;
    step(); step(); step();
    total_cnt++; if (prog_ctr !== 12'h010 || fetch_en !== 1'b0) $display("FAIL armed got pc %h fe %b exp 010 0", prog_ctr, fetch_en); else pass_cnt++;
    start = 1'b0;
    step();
    total_cnt++; if (prog_ctr !== 12'h010 || fetch_en !== 1'b1 || done !== 1'b0) $display("FAIL run0 got pc %h fe %b dn %b exp 010 1 0", prog_ctr, fetch_en, done); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h011) $display("FAIL run1 got %h exp 011", prog_ctr); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h012 || cycle_cnt !== 16'd2) $display("FAIL run2 got pc %h cnt %0d exp 012 2", prog_ctr, cycle_cnt); else pass_cnt++;
    $display("start_run: pc=%h fetch_en=%b cnt=%0d", prog_ctr, fetch_en, cycle_cnt);
  endtask

  task automatic test_halt_addr();
    arm(12'h07E);
    total_cnt++; if (prog_ctr !== 12'h07E || cycle_cnt !== 16'd0) $display("FAIL ha_start got pc %h cnt %0d exp 07E 0", prog_ctr, cycle_cnt); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h07F) $display("FAIL ha_7f got %h exp 07F", prog_ctr); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h080 || done !== 1'b0 || fetch_en !== 1'b1) $display("FAIL ha_80 got pc %h dn %b fe %b exp 080 0 1", prog_ctr, done, fetch_en); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b1 || fetch_en !== 1'b0) $display("FAIL ha_done got dn %b fe %b exp 1 0", done, fetch_en); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 16'd3) $display("FAIL ha_cnt got %0d exp 3", cycle_cnt); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h080) $display("FAIL ha_hold got %h exp 080", prog_ctr); else pass_cnt++;
    $display("halt_addr: pc=%h done=%b cnt=%0d", prog_ctr, done, cycle_cnt);
  endtask

  task automatic test_branch_jump();
    arm(12'h020);
    branch = 1'b1; taken = 1'b1; target = 12'hFFC;
    step(); clear_ctrl();
    total_cnt++; if (prog_ctr !== 12'h01C) $display("FAIL br_taken got %h exp 01C", prog_ctr); else pass_cnt++;
    arm(12'h020);
    branch = 1'b1; taken = 1'b0; target = 12'hFFC;
    step(); clear_ctrl();
    total_cnt++; if (prog_ctr !== 12'h021) $display("FAIL br_not_taken got %h exp 021", prog_ctr); else pass_cnt++;
    arm(12'h020);
    jump = 1'b1; branch = 1'b1; taken = 1'b1; target = 12'h040;
    step(); clear_ctrl();
    total_cnt++; if (prog_ctr !== 12'h040) $display("FAIL jump_wins got %h exp 040", prog_ctr); else pass_cnt++;
    $display("branch_jump: pc=%h", prog_ctr);
  endtask

  task automatic test_wrap();
    arm(12'hFFF);
    step();
    total_cnt++; if (prog_ctr !== 12'h000) $display("FAIL wrap_seq got %h exp 000", prog_ctr); else pass_cnt++;
    arm(12'h002);
    branch = 1'b1; taken = 1'b1; target = 12'hFFD;
    step(); clear_ctrl();
    total_cnt++; if (prog_ctr !== 12'hFFF) $display("FAIL wrap_branch got %h exp FFF", prog_ctr); else pass_cnt++;
    $display("wrap: pc=%h", prog_ctr);
  endtask

  task automatic test_halt();
    arm(12'h015);
    halt = 1'b1;
    step();
    total_cnt++; if (done !== 1'b1 || fetch_en !== 1'b0 || prog_ctr !== 12'h015) $display("FAIL halt_done got dn %b fe %b pc %h exp 1 0 015", done, fetch_en, prog_ctr); else pass_cnt++;
    total_cnt++; if (cycle_cnt !== 16'd1) $display("FAIL halt_cnt got %0d exp 1", cycle_cnt); else pass_cnt++;
    halt = 1'b0; jump = 1'b1; branch = 1'b1; taken = 1'b1; target = 12'h123;
    repeat (10) step();
    clear_ctrl();
    total_cnt++; if (prog_ctr !== 12'h015 || cycle_cnt !== 16'd1 || done !== 1'b1) $display("FAIL halt_hold got pc %h cnt %0d dn %b exp 015 1 1", prog_ctr, cycle_cnt, done); else pass_cnt++;
    start = 1'b1; start_address = 12'h000;
    step();
    start = 1'b0;
    total_cnt++; if (done !== 1'b0 || fetch_en !== 1'b0 || prog_ctr !== 12'h000) $display("FAIL rearm got dn %b fe %b pc %h exp 0 0 000", done, fetch_en, prog_ctr); else pass_cnt++;
    step();
    total_cnt++; if (cycle_cnt !== 16'd0 || fetch_en !== 1'b1) $display("FAIL rearm_run got cnt %0d fe %b exp 0 1", cycle_cnt, fetch_en); else pass_cnt++;
    $display("halt: pc=%h done=%b cnt=%0d", prog_ctr, done, cycle_cnt);
  endtask

  task automatic test_reset_mid_run();
    arm(12'h031);
    step(); step();
    total_cnt++; if (prog_ctr !== 12'h033) $display("FAIL pre_rst got %h exp 033", prog_ctr); else pass_cnt++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++; if (prog_ctr !== 12'h000 || fetch_en !== 1'b0 || done !== 1'b0 || cycle_cnt !== 16'd0) $display("FAIL mid_rst got pc %h fe %b dn %b cnt %0d exp 000 0 0 0", prog_ctr, fetch_en, done, cycle_cnt); else pass_cnt++;
    step();
    total_cnt++; if (prog_ctr !== 12'h000 || fetch_en !== 1'b0) $display("FAIL post_rst_idle got pc %h fe %b exp 000 0", prog_ctr, fetch_en); else pass_cnt++;
    $display("reset_mid_run: pc=%h fetch_en=%b", prog_ctr, fetch_en);
  endtask

  task automatic test_back_to_back();
    arm(12'h050);
    step(); step();
    total_cnt++; if (prog_ctr !== 12'h052) $display("FAIL b2b_run got %h exp 052", prog_ctr); else pass_cnt++;
    start = 1'b1; start_address = 12'h0A0;
    step();
    total_cnt++; if (prog_ctr !== 12'h0A0 || fetch_en !== 1'b0) $display("FAIL b2b_rearm got pc %h fe %b exp 0A0 0", prog_ctr, fetch_en); else pass_cnt++;
    start = 1'b0;
    step(); step();
    total_cnt++; if (prog_ctr !== 12'h0A1 || fetch_en !== 1'b1 || cycle_cnt !== 16'd1) $display("FAIL b2b_resume got pc %h fe %b cnt %0d exp 0A1 1 1", prog_ctr, fetch_en, cycle_cnt); else pass_cnt++;
    $display("back_to_back: pc=%h fetch_en=%b cnt=%0d", prog_ctr, fetch_en, cycle_cnt);
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_halt_addr();
    test_branch_jump();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
